spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/snn_pkg.sv | 15 +
 rtl/sat_counter.sv | 22 ++
 rtl/spike_rate_decoder.sv | 121 ++++++++++++
 tb/tb_spike_rate_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the SNN output-decoding blocks.
package snn_pkg;

  localparam int DEFAULT_NEURONS     = 8;
  localparam int DEFAULT_COUNT_BITS  = 8;
  localparam int DEFAULT_WINDOW_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    HOLD  = 2'd3
  } dec_state_t;

endpackage

// File: rtl/sat_counter.sv
// Per-neuron spike counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts output-layer spikes over a window, then reports the
// most active neuron (lowest index on ties) through a valid/ready handshake.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int NEURONS     = DEFAULT_NEURONS,
  parameter int COUNT_BITS  = DEFAULT_COUNT_BITS,
  parameter int WINDOW_BITS = DEFAULT_WINDOW_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       enable,
  input  logic [NEURONS-1:0]         spikes,
  input  logic [WINDOW_BITS-1:0]     window_len,
  input  logic                       result_ready,
  output logic                       result_valid,
  output logic [$clog2(NEURONS)-1:0] result_class,
  output logic [COUNT_BITS-1:0]      result_count,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NEURONS);

  dec_state_t             state;
  logic [WINDOW_BITS-1:0] win_len_q;
  logic [WINDOW_BITS-1:0] step_q;
  logic [IDX_W-1:0]       scan_idx;
  logic [IDX_W-1:0]       best_class;
  logic [COUNT_BITS-1:0]  best_count;
  logic [COUNT_BITS-1:0]  counts [NEURONS];

  logic                   accum_step;
  logic                   last_step;
  logic                   last_idx;
  logic [COUNT_BITS-1:0]  cand_count;
  logic [IDX_W-1:0]       cand_class;

  // start has priority over counting so a restart never leaks a stray spike
  assign accum_step = (state == ACCUM) && enable && !start;

  for (genvar i = 0; i < NEURONS; i++) begin : g_cnt
    sat_counter #(.WIDTH(COUNT_BITS)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .inc   (accum_step & spikes[i]),
      .value (counts[i])
    );
  end

  always_comb begin
    last_step  = (step_q == (win_len_q - 1'b1));
    last_idx   = (scan_idx == IDX_W'(NEURONS - 1));
    cand_count = best_count;
    cand_class = best_class;
    if (counts[scan_idx] > best_count) begin
      cand_count = counts[scan_idx];
      cand_class = scan_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      win_len_q    <= '0;
      step_q       <= '0;
      scan_idx     <= '0;
      best_class   <= '0;
      best_count   <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_count <= '0;
      busy         <= 1'b0;
    end else if (start) begin
      win_len_q    <= window_len;
      step_q       <= '0;
      scan_idx     <= '0;
      best_class   <= '0;
      best_count   <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b1;
      state        <= (window_len == '0) ? SCAN : ACCUM;
    end else begin
      case (state)
        IDLE: ;
        ACCUM: begin
          if (enable) begin
            step_q <= step_q + 1'b1;
            if (last_step) begin
              state      <= SCAN;
              scan_idx   <= '0;
              best_class <= '0;
              best_count <= '0;
            end
          end
        end
        SCAN: begin
          best_count <= cand_count;
          best_class <= cand_class;
          scan_idx   <= scan_idx + 1'b1;
          if (last_idx) begin
            state        <= HOLD;
            result_valid <= 1'b1;
            result_class <= cand_class;
            result_count <= cand_count;
            busy         <= 1'b0;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: a default-width and a 4-bit-count decoder share stimulus;
// a spike-count model predicts each window's winner.
module tb_spike_rate_decoder;

  localparam int N  = 8;
  localparam int CB = 8;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  spikes = '0;
  logic [WB-1:0] window_len = '0;
  logic          result_ready = 1'b1;

  logic          result_valid, busy;
  logic [2:0]    result_class;
  logic [CB-1:0] result_count;
  logic          result_valid4, busy4;
  logic [2:0]    result_class4;
  logic [3:0]    result_count4;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NEURONS(N), .COUNT_BITS(CB), .WINDOW_BITS(WB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .spikes(spikes),
    .window_len(window_len), .result_ready(result_ready),
    .result_valid(result_valid), .result_class(result_class),
    .result_count(result_count), .busy(busy)
  );

  spike_rate_decoder #(.NEURONS(N), .COUNT_BITS(4), .WINDOW_BITS(WB)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .spikes(spikes),
    .window_len(window_len), .result_ready(result_ready),
    .result_valid(result_valid4), .result_class(result_class4),
    .result_count(result_count4), .busy(busy4)
  );

  typedef struct {
    int cls;
    int cnt;
    int cls4;
    int cnt4;
  } exp_t;

  exp_t q[$];
  int   model_cnt [N];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   prev_valid = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t predict();
    exp_t e;
    e = '{0, 0, 0, 0};
    for (int i = 0; i < N; i++) begin
      int s8, s4;
      s8 = (model_cnt[i] > 255) ? 255 : model_cnt[i];
      s4 = (model_cnt[i] > 15) ? 15 : model_cnt[i];
      if (s8 > e.cnt)  begin e.cnt  = s8; e.cls  = i; end
      if (s4 > e.cnt4) begin e.cnt4 = s4; e.cls4 = i; end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input int wl);
    start = 1'b1;
    window_len = WB'(wl);
    enable = 1'b0;
    for (int i = 0; i < N; i++) model_cnt[i] = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic step(input logic [N-1:0] p);
    enable = 1'b1;
    spikes = p;
    for (int i = 0; i < N; i++) if (p[i]) model_cnt[i]++;
    tick();
    enable = 1'b0;
  endtask

  task automatic gap();
    enable = 1'b0;
    spikes = N'($urandom);
    tick();
  endtask

  task automatic push_expected();
    q.push_back(predict());
  endtask

  // Drives noise on enable/spikes (must be ignored) while waiting for valid.
  task automatic wait_result(input bit check_pulse);
    int c;
    c = 0;
    while (!result_valid && c < 100) begin
      enable = 1'($urandom);
      spikes = N'($urandom);
      tick();
      c++;
    end
    enable = 1'b0;
    check_eq("latency", c + 1, N + 1);
    if (check_pulse) begin
      tick();
      check_eq("valid_pulse", int'(result_valid), 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (result_valid && !prev_valid) begin
        if (q.size() == 0) begin
          check_eq("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("class", int'(result_class), e.cls);
          check_eq("count", int'(result_count), e.cnt);
          check_eq("valid4", int'(result_valid4), 1);
          check_eq("class4", int'(result_class4), e.cls4);
          check_eq("count4", int'(result_count4), e.cnt4);
        end
      end
      prev_valid = result_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #2;
    check_eq("rst_valid", int'(result_valid), 0);
    check_eq("rst_class", int'(result_class), 0);
    check_eq("rst_count", int'(result_count), 0);
    check_eq("rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // one neuron, 4 steps
    result_ready = 1'b1;
    begin_window(4);
    check_eq("busy_accum", int'(busy), 1);
    repeat (4) step(8'b0000_0100);
    push_expected();
    wait_result(1'b1);
    check_eq("idle_busy", int'(busy), 0);

    // tie between 0 and 7, gaps between steps not counted
    begin_window(3);
    step(8'h81); gap(); step(8'h81); gap(); step(8'h81);
    push_expected();
    wait_result(1'b1);

    // saturation in the 4-bit instance
    begin_window(20);
    for (int s = 0; s < 20; s++) step((s % 2 == 0) ? 8'h22 : 8'h20);
    push_expected();
    wait_result(1'b1);

    // random patterns with gaps
    for (int w = 0; w < 3; w++) begin
      int wl;
      wl = 5 + w * 3;
      begin_window(wl);
      for (int s = 0; s < wl; s++) begin
        if ($urandom_range(0, 2) == 0) gap();
        step(N'($urandom));
      end
      push_expected();
      wait_result(1'b1);
    end

    // hold without ready, outputs stable, then start drops the result
    result_ready = 1'b0;
    begin_window(6);
    for (int s = 0; s < 6; s++) step(N'($urandom));
    push_expected();
    e = predict();
    wait_result(1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("hold_valid", int'(result_valid), 1);
      check_eq("hold_class", int'(result_class), e.cls);
      check_eq("hold_count", int'(result_count), e.cnt);
    end
    begin_window(2);
    check_eq("drop_valid", int'(result_valid), 0);
    check_eq("drop_busy", int'(busy), 1);
    step(8'h10); step(8'h18);
    push_expected();
    result_ready = 1'b1;
    wait_result(1'b0);

    // start coincident with handshake
    begin_window(3);
    check_eq("hs_valid", int'(result_valid), 0);
    check_eq("hs_busy", int'(busy), 1);
    step(8'h40); step(8'h41); step(8'h40);
    push_expected();
    wait_result(1'b1);

    // zero-length window goes straight to scan
    begin_window(0);
    push_expected();
    wait_result(1'b1);

    // reset mid-accumulation discards the window
    begin_window(5);
    step(8'hFF); step(8'hFF);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", int'(result_valid), 0);
    check_eq("mrst_class", int'(result_class), 0);
    check_eq("mrst_count", int'(result_count), 0);
    check_eq("mrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      enable = 1'($urandom);
      spikes = N'($urandom);
      tick();
    end
    enable = 1'b0;
    check_eq("post_rst_valid", int'(result_valid), 0);
    check_eq("post_rst_busy", int'(busy), 0);

    check_eq("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
